// File: rtl/passcode_pkg.sv
// Shared constants for the passcode entry controller: state encoding,
// digit width and the factory default code.
package passcode_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ENTRY = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_OPEN  = 3'd3;
    localparam logic [2:0] ST_FAIL  = 3'd4;
    localparam logic [2:0] ST_LOCK  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_ENTRY = ST_ENTRY,
        S_CHECK = ST_CHECK,
        S_OPEN  = ST_OPEN,
        S_FAIL  = ST_FAIL,
        S_LOCK  = ST_LOCK
    } state_t;

    localparam logic [15:0] DEFAULT_CODE = 16'h1234;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that stops at zero; done flags a count of zero.
// Synchronous active-low reset, frozen while en is low.
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         done
);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            count <= '0;
        end else if (en) begin
            if (load) begin
                count <= load_val;
            end else if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/passcode_ctrl.sv
// Passcode entry controller: buffers shaped digit pulses, checks them against
// CODE, drives Unlock/Fail/Locked. Lockout is built only with PASSCODE_LOCKOUT_EN.
module passcode_ctrl
    import passcode_pkg::*;
#(
    parameter int                               NUM_DIGITS  = 4,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0]    CODE        = (NUM_DIGITS*DIGIT_W)'(DEFAULT_CODE),
    parameter int                               OPEN_CYCLES = 1000,
    parameter int                               MAX_TRIES   = 3,
    parameter int                               LOCK_CYCLES = 5000
) (
    input  logic                                Clk,
    input  logic                                Rst,
    input  logic                                En,
    input  logic [DIGIT_W-1:0]                  Digit_in,
    input  logic                                Digit_vld,
    input  logic                                Enter,
    input  logic                                Clear,
    output logic                                Unlock,
    output logic                                Fail,
    output logic                                Locked,
    output logic [$clog2(NUM_DIGITS+1)-1:0]     Count,
    output logic [2:0]                          Dbg_state
);

    localparam int BW   = NUM_DIGITS * DIGIT_W;
    localparam int CW   = $clog2(NUM_DIGITS + 1);
    localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int TRW  = $clog2(MAX_TRIES + 1);

    // Inputs are one-cycle pulses with no back-pressure: a pulse is consumed
    // on the edge it is seen with En high, otherwise it is lost.
    state_t          state, state_nx;
    logic [BW-1:0]   code_buf, buf_nx;
    logic [CW-1:0]   cnt_q, cnt_nx;
    logic            tmr_load;
    logic [TW-1:0]   tmr_val, tmr_cnt;
    logic            tmr_done, tmr_last;
    logic            match, lock_trip, fail_q;

    cycle_timer #(.W(TW)) u_timer (
        .Clk      (Clk),
        .Rst      (Rst),
        .en       (En),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_cnt),
        .done     (tmr_done)
    );

    // Leaving on the edge that drains the timer gives exactly N high cycles.
    assign tmr_last = tmr_done || (tmr_cnt == TW'(1));
    assign match    = (cnt_q == CW'(NUM_DIGITS)) && (code_buf == CODE);

`ifdef PASSCODE_LOCKOUT_EN
    logic [TRW-1:0] tries_q;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            tries_q <= '0;
        end else if (En) begin
            if (state == S_CHECK) begin
                tries_q <= match ? '0 :
                           (tries_q == TRW'(MAX_TRIES)) ? tries_q : tries_q + 1'b1;
            end else if (state == S_LOCK && tmr_last) begin
                tries_q <= '0;
            end
        end
    end

    assign lock_trip = (tries_q == TRW'(MAX_TRIES));
    assign Locked    = (state == S_LOCK);
`else
    assign lock_trip = 1'b0;
    assign Locked    = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        buf_nx   = code_buf;
        cnt_nx   = cnt_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            S_IDLE: begin
                if (Digit_vld) begin
                    buf_nx   = BW'(Digit_in);
                    cnt_nx   = CW'(1);
                    state_nx = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (Clear) begin
                    buf_nx   = '0;
                    cnt_nx   = '0;
                    state_nx = S_IDLE;
                end else if (Enter) begin
                    state_nx = S_CHECK;
                end else if (Digit_vld && cnt_q < CW'(NUM_DIGITS)) begin
                    buf_nx = (code_buf << DIGIT_W) | BW'(Digit_in);
                    cnt_nx = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                buf_nx = '0;
                cnt_nx = '0;
                if (match) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(OPEN_CYCLES);
                    state_nx = S_OPEN;
                end else begin
                    state_nx = S_FAIL;
                end
            end
            S_OPEN: begin
                if (Clear || tmr_last) state_nx = S_IDLE;
            end
            S_FAIL: begin
                if (lock_trip) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(LOCK_CYCLES);
                    state_nx = S_LOCK;
                end else begin
                    state_nx = S_IDLE;
                end
            end
`ifdef PASSCODE_LOCKOUT_EN
            S_LOCK: begin
                if (tmr_last) state_nx = S_IDLE;
            end
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state    <= S_IDLE;
            code_buf <= '0;
            cnt_q    <= '0;
        end else if (En) begin
            state    <= state_nx;
            code_buf <= buf_nx;
            cnt_q    <= cnt_nx;
        end
    end

    // Registered so it is one cycle per mismatch and drops at once when En is low.
    always_ff @(posedge Clk) begin
        if (!Rst) fail_q <= 1'b0;
        else      fail_q <= En && (state == S_CHECK) && !match;
    end

    assign Unlock    = (state == S_OPEN);
    assign Fail      = fail_q;
    assign Count     = cnt_q;
    assign Dbg_state = state;

endmodule

// File: tb/tb_passcode_ctrl.sv
// Randomized bench for passcode_ctrl with a queue-based reference model;
// lockout expectations follow PASSCODE_LOCKOUT_EN.
module tb_passcode_ctrl;

    localparam int          N      = 4;
    localparam logic [15:0] CODE_V = 16'h1234;
    localparam int          OPEN_C = 8;
    localparam int          MAX_T  = 3;
    localparam int          LOCK_C = 16;
`ifdef PASSCODE_LOCKOUT_EN
    localparam bit LOCKOUT = 1'b1;
`else
    localparam bit LOCKOUT = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       En = 1'b0;
    logic [3:0] Digit_in = 4'd0;
    logic       Digit_vld = 1'b0;
    logic       Enter = 1'b0;
    logic       Clear = 1'b0;
    logic       Unlock, Fail, Locked;
    logic [2:0] Count;
    logic [2:0] Dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    passcode_ctrl #(
        .NUM_DIGITS  (N),
        .CODE        (CODE_V),
        .OPEN_CYCLES (OPEN_C),
        .MAX_TRIES   (MAX_T),
        .LOCK_CYCLES (LOCK_C)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .En        (En),
        .Digit_in  (Digit_in),
        .Digit_vld (Digit_vld),
        .Enter     (Enter),
        .Clear     (Clear),
        .Unlock    (Unlock),
        .Fail      (Fail),
        .Locked    (Locked),
        .Count     (Count),
        .Dbg_state (Dbg_state)
    );

    always #5 Clk = ~Clk;

    // Reference model: entered digits, remaining open/lock cycles, pending check/fail.
    logic [3:0] exp_q[$];
    int open_left = 0;
    int lock_left = 0;
    int tries     = 0;
    bit checking  = 1'b0;
    bit failing   = 1'b0;
    bit fail_out  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] code_digit(input int i);
        logic [15:0] c;
        c = CODE_V;
        return c[4*(N-1-i) +: 4];
    endfunction

    function automatic bit code_ok();
        if (exp_q.size() != N) return 1'b0;
        for (int i = 0; i < N; i++)
            if (exp_q[i] != code_digit(i)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        if (!Rst) begin
            exp_q.delete();
            open_left = 0; lock_left = 0; tries = 0;
            checking = 0; failing = 0; fail_out = 0;
        end else if (!En) begin
            fail_out = 0;
        end else begin
            fail_out = 0;
            if (lock_left > 0) begin
                lock_left--;
                if (lock_left == 0) tries = 0;
            end else if (open_left > 0) begin
                if (Clear) open_left = 0;
                else       open_left--;
            end else if (checking) begin
                checking = 0;
                if (code_ok()) begin
                    tries = 0;
                    open_left = OPEN_C;
                end else begin
                    if (tries < MAX_T) tries++;
                    fail_out = 1;
                    failing = 1;
                end
                exp_q.delete();
            end else if (failing) begin
                failing = 0;
                if (LOCKOUT && tries == MAX_T) lock_left = LOCK_C;
            end else if (exp_q.size() == 0) begin
                if (Digit_vld) exp_q.push_back(Digit_in);
            end else begin
                if (Clear)                                exp_q.delete();
                else if (Enter)                           checking = 1;
                else if (Digit_vld && exp_q.size() < N)   exp_q.push_back(Digit_in);
            end
        end
    endtask

    task automatic compare_outputs();
        check("unlock", {31'd0, Unlock}, {31'd0, open_left > 0});
        check("fail",   {31'd0, Fail},   {31'd0, fail_out});
        check("locked", {31'd0, Locked}, {31'd0, lock_left > 0});
        check("count",  {29'd0, Count},  32'(exp_q.size()));
    endtask

    task automatic cycle(input bit en, input bit dv, input logic [3:0] d,
                         input bit ent, input bit clr);
        En = en; Digit_vld = dv; Digit_in = d; Enter = ent; Clear = clr;
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        compare_outputs();
        En = 1'b1; Digit_vld = 1'b0; Enter = 1'b0; Clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 4'd0, 0, 0);
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        cycle(1, 0, 4'd0, 0, 0);
        cycle(0, 1, 4'd3, 1, 1);
        Rst = 1'b1;
    endtask

    // Digits packed first-entered in the most significant used nibble.
    task automatic enter_code(input logic [31:0] digits, input int n);
        for (int i = 0; i < n; i++) cycle(1, 1, digits[4*(n-1-i) +: 4], 0, 0);
        cycle(1, 0, 4'd0, 1, 0);
    endtask

    initial begin
        @(negedge Clk);
        do_reset();
        check("reset_state", {29'd0, Dbg_state}, 32'd0);

        enter_code(32'h1234, 4);   idle(12);
        enter_code(32'h1235, 4);   idle(3);
        enter_code(32'h123, 3);    idle(3);
        enter_code(32'h9999, 4);   idle(2);
        for (int i = 0; i < 20; i++)
            cycle(1, i[0], 4'(i), 1'b0, ~i[0]);
        enter_code(32'h1234, 4);   idle(10);
        enter_code(32'h12349, 5);  idle(10);

        cycle(1, 1, 4'd1, 0, 0);
        cycle(1, 1, 4'd2, 0, 0);
        cycle(1, 1, 4'd7, 1, 1);
        idle(2);

        enter_code(32'h1234, 4);   idle(3);
        cycle(0, 0, 4'd0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 4'd5, 0, 0);
        idle(10);

        enter_code(32'h1111, 4);   idle(2);
        enter_code(32'h2222, 4);   idle(2);
        enter_code(32'h3333, 4);   idle(5);
        do_reset();
        check("reset_mid_lock_state", {29'd0, Dbg_state}, 32'd0);
        enter_code(32'h4444, 4);   idle(2);
        enter_code(32'h5555, 4);   idle(3);
        enter_code(32'h6666, 4);   idle(20);

        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: begin enter_code(32'h1234, 4); idle($urandom_range(1, 10)); end
                1: begin
                    int n;
                    logic [31:0] ds;
                    n  = $urandom_range(1, 5);
                    ds = $urandom;
                    if ($urandom_range(0, 1) == 1) ds = {ds[31:12], 12'h234};
                    enter_code(ds, n);
                    idle($urandom_range(1, 4));
                end
                default: begin
                    for (int k = 0; k < 12; k++) begin
                        int p;
                        p = $urandom_range(0, 3);
                        cycle($urandom_range(0, 5) != 0, p == 1, 4'($urandom_range(1, 5)),
                              p == 2, p == 3);
                    end
                end
            endcase
        end
        idle(20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/passcode_ctrl.md
# passcode_ctrl

Passcode entry controller for the medicine-reminder lock path. It consumes the one-cycle pulses produced by the button shapers (digit strobe, Enter, Clear) and accumulates a fixed-length digit sequence. It then compares the sequence against a parameterised code and drives the unlock/fail/lockout indications seen by the reminder and display logic. It sits directly downstream of the button shapers and upstream of the dispenser enable.

## Interface
- `NUM_DIGITS`, 4: digits per passcode (1..8).
- `CODE`, 16'h1234: expected code, 4 bits per digit, first-entered digit in the MS nibble; width `NUM_DIGITS*4`.
- `OPEN_CYCLES`, 1000: clocks `Unlock` stays high after a match (≥1).
- `MAX_TRIES`, 3: consecutive failures that trigger lockout (≥1).
- `LOCK_CYCLES`, 5000: clocks of lockout (≥1).

Ports:
- `Clk`, input, 1: clock.
- `Rst`, input, 1: reset, synchronous, active-low.
- `En`, input, 1: global enable; low freezes state, buffer, counters and timer.
- `Digit_in`, input, 4: digit value, sampled only when `Digit_vld`=1.
- `Digit_vld`, input, 1: one-cycle shaped digit strobe.
- `Enter`, input, 1: one-cycle shaped submit pulse.
- `Clear`, input, 1: one-cycle shaped abort pulse.
- `Unlock`, output, 1: high while the block is in S_OPEN.
- `Fail`, output, 1: one-cycle pulse on each mismatch.
- `Locked`, output, 1: high while the block is in S_LOCK.
- `Count`, output, `$clog2(NUM_DIGITS+1)`: digits currently buffered, for the display.

## Operation
- States: S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_FAIL, S_LOCK.
- Reset (Rst=0 at a Clk edge, overrides En):
  - State goes to S_IDLE.
  - Buffer is cleared to 0, `Count`=0, tries=0, timer=0.
  - `Unlock`=0, `Fail`=0, `Locked`=0.
  - A reset in any state, including mid-OPEN or mid-LOCK, aborts immediately.
- Input priority within one cycle: Clear > Enter > Digit_vld.
- S_IDLE:
  - Digit_vld loads the buffer with {0…, Digit_in}, sets `Count`=1 and goes to S_ENTRY.
  - Enter and Clear are ignored.
- S_ENTRY:
  - Digit_vld with `Count`<NUM_DIGITS shifts the digit into the buffer (`buf <= {buf[4*NUM_DIGITS-5:0], Digit_in}`) and increments `Count`.
  - Digit_vld with `Count`==NUM_DIGITS is ignored; no wrap, no overwrite.
  - Enter goes to S_CHECK.
  - Clear clears the buffer, sets `Count`=0 and goes to S_IDLE.
- S_CHECK (exactly 1 cycle):
  - Match requires `Count`==NUM_DIGITS and buf==CODE.
  - On a match: tries=0, timer loaded with OPEN_CYCLES, go to S_OPEN.
  - Otherwise: tries+1 (saturating at MAX_TRIES), go to S_FAIL.
  - In both cases the buffer and `Count` are cleared.
- S_OPEN:
  - Timer decrements each enabled cycle.
  - When the timer reaches 0, or on Clear, go to S_IDLE.
  - Digit_vld and Enter are ignored.
- S_FAIL (exactly 1 cycle):
  - If lockout is compiled in and tries==MAX_TRIES: load timer with LOCK_CYCLES and go to S_LOCK.
  - Otherwise go to S_IDLE.
- S_LOCK:
  - All inputs are ignored, Clear included.
  - The timer decrements; when it reaches 0, tries=0 and the block goes to S_IDLE.
- Arithmetic:
  - Digit values 0xA–0xF are stored as-is, with no range check.
  - The timer is an unsigned down-counter, width `$clog2(max(OPEN_CYCLES,LOCK_CYCLES)+1)`.
  - tries width is `$clog2(MAX_TRIES+1)`.

## Timing
- All outputs are Moore, decoded from registered state or registered counters; there is no combinational input-to-output path.
- Enter is sampled at edge k: S_CHECK after k, then S_OPEN or S_FAIL after k+1.
  - `Unlock` or `Fail` is first high in the cycle following edge k+1.
- `Unlock` lasts exactly OPEN_CYCLES cycles when En stays high; `Locked` lasts exactly LOCK_CYCLES.
- `Fail` is high for exactly one cycle per mismatch.
- En=0: no state or register updates, and input pulses in that cycle are lost.
  - Outputs hold their values, except `Fail`, which is forced to 0.

## Configuration
- `PASSCODE_LOCKOUT_EN` defined:
  - The tries counter, S_LOCK and the `Locked` output logic are implemented.
- `PASSCODE_LOCKOUT_EN` undefined:
  - The tries counter and S_LOCK are removed and `Locked` is tied to 0.
  - S_FAIL always returns to S_IDLE; unlimited retries.

## Structure
- `passcode_pkg` holds:
  - the state encoding localparams (3-bit);
  - the digit width constant (4);
  - the default CODE.
- Sub-module `cycle_timer`: a loadable down-counter with `load`, `load_val`, `en` and a `done` (==0) flag.
  - One instance serves both the OPEN and LOCK durations.
  - It uses the same Clk/Rst conventions as the parent.

## Test plan
Bench parameters: NUM_DIGITS=4, CODE=16'h1234, OPEN_CYCLES=8, MAX_TRIES=3, LOCK_CYCLES=16.
- Correct code: digits 1,2,3,4 then Enter → `Unlock`=1 two cycles after Enter is sampled, for 8 cycles; `Fail` stays 0.
- Wrong or short codes:
  - Digits 1,2,3,5 then Enter → one-cycle `Fail`, back to S_IDLE.
  - Digits 1,2,3 then Enter → `Fail` (count mismatch).
- Lockout:
  - Three wrong entries → `Locked`=1 for 16 cycles, and digits and Clear are ignored during it.
  - Then 1,2,3,4 and Enter → `Unlock`.
  - Without the macro, `Locked` never asserts.
- Buffer and priority rules:
  - Digits 1,2,3,4,9 then Enter → unlock, because the 5th digit is ignored.
  - Digit_vld, Enter and Clear in the same cycle during S_ENTRY → Clear wins, `Count`=0.
- Enable and reset:
  - En=0 for 5 cycles mid-S_OPEN → `Unlock` is extended by 5 cycles.
  - Rst=0 mid-S_LOCK → all outputs are 0 on the next edge and tries=0.
